// File: rtl/ahbl_trace_pkg.sv
// rtl/ahbl_trace_pkg.sv - shared encodings and widths for the AHB-Lite trace capture block
package ahbl_trace_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_DATA = 1'b1
  } cap_state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DROP_W = 8;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous first-word-fall-through record FIFO
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid & m_tready;
  // A pop on the same edge frees the slot, so a full FIFO can still take a push.
  assign s_tready = (count != (AW+1)'(DEPTH)) | pop;
  assign push     = s_tvalid & s_tready;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/ahbl_trace_capture.sv
// rtl/ahbl_trace_capture.sv - passive AHB-Lite snooper that timestamps completed transfers into a FIFO
module ahbl_trace_capture
  import ahbl_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [31:0]       haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [31:0]       hwdata_i,
  input  logic [31:0]       hrdata_i,
  output logic              rec_valid_o,
  input  logic              rec_ready_i,
  output logic [31:0]       rec_addr_o,
  output logic [31:0]       rec_data_o,
  output logic              rec_write_o,
  output logic [TS_W-1:0]   rec_ts_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int REC_W = ADDR_W + DATA_W + 1 + TS_W;

  cap_state_e        state;
  cap_state_e        state_nxt;
  logic              addr_phase;
  logic              push;
  logic              fifo_ready;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_write;
  logic [TS_W-1:0]   ts_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic [REC_W-1:0]  push_rec;
  logic [REC_W-1:0]  head_rec;

  assign addr_phase = ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ)) && hready_i && en_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= CAP_IDLE;
    else       state <= state_nxt;
  end

  // A completing data phase with a new address phase on the same edge stays in CAP_DATA.
  always_comb begin
    state_nxt = state;
    case (state)
      CAP_IDLE: if (addr_phase) state_nxt = CAP_DATA;
      CAP_DATA: if (hready_i && !addr_phase) state_nxt = CAP_IDLE;
      default:  state_nxt = CAP_IDLE;
    endcase
  end

  always_comb begin
    push = 1'b0;
    if (state == CAP_DATA && hready_i) push = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_addr  <= '0;
      pend_write <= 1'b0;
    end else if (addr_phase) begin
      pend_addr  <= haddr_i;
      pend_write <= hwrite_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  drop_cnt <= '0;
    else if (push && !fifo_ready) drop_cnt <= sat_inc(drop_cnt);
  end

  assign push_rec   = {pend_addr, (pend_write ? hwdata_i : hrdata_i), pend_write, ts_cnt};
  assign drop_cnt_o = drop_cnt;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .s_tdata  (push_rec),
    .s_tvalid (push),
    .s_tready (fifo_ready),
    .m_tdata  (head_rec),
    .m_tvalid (rec_valid_o),
    .m_tready (rec_ready_i)
  );

  assign {rec_addr_o, rec_data_o, rec_write_o, rec_ts_o} = head_rec;

endmodule

// File: doc/ahbl_trace_capture.md
AHBL_TRACE_CAPTURE -- requirements
Module: ahbl_trace_capture

Interface
REQ-001 Parameter DEPTH, default 8, record FIFO depth; power of two, at least 2.
REQ-002 Parameter TS_W, default 16, timestamp width in bits.
REQ-003 clk_i  input  1  clock; the SoC clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous assert, active-high.
REQ-005 en_i  input  1  capture enable; sampled at the address phase.
REQ-006 haddr_i  input  32  snooped AHB-Lite HADDR.
REQ-007 htrans_i  input  2  snooped HTRANS; only bit 1 is used.
REQ-008 hwrite_i  input  1  snooped HWRITE.
REQ-009 hready_i  input  1  snooped HREADY.
REQ-010 hwdata_i  input  32  snooped HWDATA.
REQ-011 hrdata_i  input  32  snooped HRDATA.
REQ-012 rec_valid_o  output  1  a record is available.
REQ-013 rec_ready_i  input  1  consumer accepts the record.
REQ-014 rec_addr_o  output  32  transfer address.
REQ-015 rec_data_o  output  32  write data or read data.
REQ-016 rec_write_o  output  1  1 = write transfer.
REQ-017 rec_ts_o  output  TS_W  timestamp of data-phase completion.
REQ-018 drop_cnt_o  output  8  count of records lost to a full FIFO.

Function
REQ-019 Address-phase accept:
- Condition: htrans_i[1] & hready_i & en_i on a rising edge.
- Action: latch haddr_i and hwrite_i into a pending register and set pend=1.
REQ-020 Data-phase completion:
- Condition: first later edge with hready_i=1 while pend=1.
- Record data: hwdata_i when the write flag is set, otherwise hrdata_i.
- Record timestamp: the free-running counter value at that edge.
REQ-021 Back-to-back transfers:
- A completion and a new address-phase accept on the same edge are both honoured.
- pend stays 1 and holds the new address.
REQ-022 Records with hready_i=0 wait states are not recorded until hready_i returns to 1.
REQ-023 Timestamp counter: TS_W bits, increments every cycle, wraps from all-ones to 0, no flag on wrap.
REQ-024 FIFO is first-word-fall-through:
- The record outputs show the head entry whenever rec_valid_o=1.
- A pop occurs on rec_valid_o & rec_ready_i.
REQ-025 Push into a full FIFO:
- The record is discarded.
- drop_cnt_o increments and saturates at 255.
REQ-026 Push and pop on the same edge with the FIFO full: the pop frees a slot, the push is accepted, drop_cnt_o is unchanged.
REQ-027 Push and pop on the same edge with the FIFO empty: the record is stored and rec_valid_o rises on the next cycle; no combinational bypass.
REQ-028 Latency: a completion edge makes rec_valid_o=1 one cycle later when the FIFO was empty.
REQ-029 en_i deasserted mid-transfer does not cancel an already pending data phase.
REQ-030 The block never drives the bus and has no effect on HREADY.

Reset
REQ-031 On rst_i the following clear:
- pend=0, FIFO pointers and occupancy=0, rec_valid_o=0.
- rec_addr_o, rec_data_o, rec_write_o, rec_ts_o=0.
- Timestamp counter=0, drop_cnt_o=0.
REQ-032 Reset asserted mid-transfer discards the pending transfer and all stored records; no record is produced after release for a transfer that started before reset.

Structure
REQ-033 The shared package ahbl_trace_pkg holds:
- HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
- Record field widths.
- Drop-counter width (8).
REQ-034 Sub-module trace_fifo: a synchronous FWFT FIFO parameterised by width and DEPTH; the capture FSM and timestamp logic stay in the top module.

Verification
REQ-035 Single write:
- Stimulus: NONSEQ write to 0x0000_1000 with hwdata 0xDEAD_BEEF, zero wait states.
- Response: one record {0x1000, 0xDEADBEEF, write=1}; rec_ts_o equals the counter at completion.
REQ-036 Read with 3 wait states:
- Stimulus: read from 0x2000, hready_i low for 3 cycles, hrdata 0x1234_5678 on the final cycle.
- Response: exactly one record with data 0x12345678, timestamp 3 greater than a zero-wait read issued at the same time.
REQ-037 Pipelined burst:
- Stimulus: 4 back-to-back NONSEQ/SEQ reads to 0x100..0x10C with rec_ready_i=1.
- Response: 4 records in order with no gaps.
REQ-038 Overflow:
- Stimulus: rec_ready_i=0, 10 writes with DEPTH=8.
- Response: 8 records retained (first 8), drop_cnt_o=2; all 8 records then drain in order once ready rises.
REQ-039 Full FIFO with simultaneous push and pop:
- Response: the record is accepted and drop_cnt_o is unchanged.
- Additional stimulus: 300 dropped writes.
- Response: drop_cnt_o=255.
REQ-040 Reset mid-data-phase:
- Stimulus: assert rst_i while pend=1.
- Response: rec_valid_o=0 and drop_cnt_o=0; no record appears after release.
